// File: rtl/iq_snapshot_capture.sv
// iq_snapshot_capture: packs 1-bit I/Q samples into RAM words for one snapshot and serves word reads.
module iq_snapshot_capture #(
  parameter int PACK_W = 16,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_i,
  input  logic              in_q,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PACK_W-1:0] rd_data_i,
  output logic [PACK_W-1:0] rd_data_q,
  output logic              rd_valid
);
  localparam int CW = $clog2(PACK_W);
  typedef enum logic [1:0] {IDLE, CAPTURE, FINISH} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] wp_q, wp_d;
  logic [ADDR_W:0] wc_q, wc_d;
  logic [PACK_W-1:0] pi_q, pi_d, pq_q, pq_d, rdi_q, rdi_d, rdq_q, rdq_d;
  logic rv_q, rv_d, shift, wr, last;
  logic [PACK_W-1:0] mem_i [DEPTH];
  logic [PACK_W-1:0] mem_q [DEPTH];
  always_comb begin
    shift = state_q == CAPTURE && in_valid;
    wr = shift && cnt_q == CW'(PACK_W - 1);
    last = wr && wp_q == ADDR_W'(DEPTH - 1);
    // shifting in at the MSB leaves the first sample of a word in bit 0
    pi_d = shift ? {in_i, pi_q[PACK_W-1:1]} : pi_q;
    pq_d = shift ? {in_q, pq_q[PACK_W-1:1]} : pq_q;
    state_d = (state_q == IDLE && start) ? CAPTURE :
              (state_q == FINISH) ? IDLE :
              last ? FINISH :
              (state_q == CAPTURE && abort) ? IDLE : state_q;
    cnt_d = (state_q == IDLE && start) ? '0 : shift ? cnt_q + CW'(1) : cnt_q;
    wp_d = (state_q == IDLE && start) ? '0 : wr ? wp_q + ADDR_W'(1) : wp_q;
    wc_d = (state_q == IDLE && start) ? '0 : wr ? wc_q + (ADDR_W+1)'(1) : wc_q;
    rv_d = rd_en;
    rdi_d = rd_en ? mem_i[rd_addr] : rdi_q;
    rdq_d = rd_en ? mem_q[rd_addr] : rdq_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      wp_q <= '0;
      wc_q <= '0;
      pi_q <= '0;
      pq_q <= '0;
      rv_q <= 1'b0;
      rdi_q <= '0;
      rdq_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wp_q <= wp_d;
      wc_q <= wc_d;
      pi_q <= pi_d;
      pq_q <= pq_d;
      rv_q <= rv_d;
      rdi_q <= rdi_d;
      rdq_q <= rdq_d;
    end
  always_ff @(posedge clk)
    if (wr) begin
      mem_i[wp_q] <= pi_d;
      mem_q[wp_q] <= pq_d;
    end
  assign busy = state_q == CAPTURE;
  assign done = state_q == FINISH;
  assign word_count = wc_q;
  assign rd_valid = rv_q;
  assign rd_data_i = rdi_q;
  assign rd_data_q = rdq_q;
endmodule
